// File: rtl/serial_pair_transmitter.sv
// Parallel-to-serial front end: captures an operand pair and emits it as two bit streams, each frame led by a clear pulse.
// Optional build macro SERIAL_PAIR_TRANSMITTER_MSB_FIRST_EN selects MSB-first order (default LSB-first).
module serial_pair_transmitter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             up_valid,
   output logic             up_ready,
   input  logic [WIDTH-1:0] up_a,
   input  logic [WIDTH-1:0] up_b,
   output logic             clear,
   output logic             a,
   output logic             b,
   output logic             bit_valid,
   output logic             last,
   output logic             busy
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_CLEAR = 2'd1;
   localparam logic [1:0] ST_SHIFT = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] sr_a_q, sr_a_d;
   logic [WIDTH-1:0] sr_b_q, sr_b_d;

   logic at_last;
   logic ready_int;
   logic take;
   logic head_a;
   logic head_b;

   assign at_last   = (state_q == ST_SHIFT) && (cnt_q == LAST_CNT);
   assign ready_int = (state_q == ST_IDLE) || at_last;
   assign take      = up_valid && ready_int;

`ifdef SERIAL_PAIR_TRANSMITTER_MSB_FIRST_EN
   assign head_a = sr_a_q[WIDTH-1];
   assign head_b = sr_b_q[WIDTH-1];
`else
   assign head_a = sr_a_q[0];
   assign head_b = sr_b_q[0];
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sr_a_d  = sr_a_q;
      sr_b_d  = sr_b_q;
      case (state_q)
         ST_IDLE: begin
            if (take) begin
               sr_a_d  = up_a;
               sr_b_d  = up_b;
               state_d = ST_CLEAR;
            end
         end
         ST_CLEAR: begin
            cnt_d   = '0;
            state_d = ST_SHIFT;
         end
         ST_SHIFT: begin
            if (at_last) begin
               // The last bit cycle doubles as the accept slot for the next pair.
               if (take) begin
                  sr_a_d  = up_a;
                  sr_b_d  = up_b;
                  state_d = ST_CLEAR;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
`ifdef SERIAL_PAIR_TRANSMITTER_MSB_FIRST_EN
               sr_a_d = {sr_a_q[WIDTH-2:0], 1'b0};
               sr_b_d = {sr_b_q[WIDTH-2:0], 1'b0};
`else
               sr_a_d = {1'b0, sr_a_q[WIDTH-1:1]};
               sr_b_d = {1'b0, sr_b_q[WIDTH-1:1]};
`endif
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         sr_a_q  <= '0;
         sr_b_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sr_a_q  <= sr_a_d;
         sr_b_q  <= sr_b_d;
      end
   end

   // Reset parks the FSM in IDLE, so ready is masked while rst is held to keep it low during reset.
   assign up_ready  = ready_int && !rst;
   assign clear     = (state_q == ST_CLEAR);
   assign bit_valid = (state_q == ST_SHIFT);
   assign a         = bit_valid && head_a;
   assign b         = bit_valid && head_b;
   assign last      = at_last;
   assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_serial_pair_transmitter.sv
// Directed bench for serial_pair_transmitter: WIDTH=16 and WIDTH=2 instances, table-driven frames plus corner sequences.
module tb_serial_pair_transmitter;

   logic        clk = 1'b0;
   logic        rst;
   logic        up_valid;
   logic        up_ready;
   logic [15:0] up_a;
   logic [15:0] up_b;
   logic        clear, a, b, bit_valid, last, busy;

   logic        s_valid;
   logic        s_ready;
   logic [1:0]  s_a;
   logic [1:0]  s_b;
   logic        s_clear, s_ao, s_bo, s_bit_valid, s_last, s_busy;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   int clear_cyc      = 0;
   int clear_cyc_prev = 0;

   // Each record: operands, then emission sequence (first bit at the left) for LSB-first and MSB-first builds.
   typedef struct {
      logic [15:0] pa;
      logic [15:0] pb;
      logic [15:0] la;
      logic [15:0] lb;
      logic [15:0] ma;
      logic [15:0] mb;
   } vec_t;
   vec_t vecs[4];

   serial_pair_transmitter #(.WIDTH(16)) u_dut (
      .clk(clk), .rst(rst), .up_valid(up_valid), .up_ready(up_ready),
      .up_a(up_a), .up_b(up_b), .clear(clear), .a(a), .b(b),
      .bit_valid(bit_valid), .last(last), .busy(busy)
   );

   serial_pair_transmitter #(.WIDTH(2)) u_dut2 (
      .clk(clk), .rst(rst), .up_valid(s_valid), .up_ready(s_ready),
      .up_a(s_a), .up_b(s_b), .clear(s_clear), .a(s_ao), .b(s_bo),
      .bit_valid(s_bit_valid), .last(s_last), .busy(s_busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, checks %0d/%0d", n_pass, n_checks);
      $fatal(1, "watchdog");
   end

   function automatic logic [6:0] st1();
      return {clear, a, b, bit_valid, last, up_ready, busy};
   endfunction

   function automatic logic [6:0] st2();
      return {s_clear, s_ao, s_bo, s_bit_valid, s_last, s_ready, s_busy};
   endfunction

   function automatic logic [15:0] sel(input logic [15:0] lsb_seq, input logic [15:0] msb_seq);
`ifdef SERIAL_PAIR_TRANSMITTER_MSB_FIRST_EN
      return msb_seq;
`else
      return lsb_seq;
`endif
   endfunction

   task automatic check(input string name, input logic [6:0] got, input logic [6:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %b expected %b {clear,a,b,bit_valid,last,up_ready,busy} at %0t",
                    name, got, exp, $time);
   endtask

   task automatic check_int(input string name, input int got, input int exp);
      n_checks++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, got, exp);
   endtask

   // Waits (bounded) for up_ready, then performs one transfer and drops up_valid just after the edge.
   task automatic start_xfer(input logic [15:0] pa, input logic [15:0] pb);
      for (int i = 0; i < 20 && !up_ready; i++) @(negedge clk);
      check_int("xfer ready", int'(up_ready), 1);
      up_valid = 1'b1;
      up_a     = pa;
      up_b     = pb;
      @(posedge clk);
      #1 up_valid = 1'b0;
   endtask

   // Checks the clear cycle and n_bits bit cycles; from bit bp_from on, offers a changing pair.
   task automatic check_frame(input string tag, input logic [15:0] sa, input logic [15:0] sb,
                              input int bp_from, input int n_bits);
      logic lb;
      @(negedge clk);
      clear_cyc_prev = clear_cyc;
      clear_cyc      = cyc;
      check({tag, " clear"}, st1(), 7'b1000001);
      for (int k = 0; k < n_bits; k++) begin
         @(negedge clk);
         lb = (k == 15);
         check($sformatf("%s bit%0d", tag, k), st1(), {1'b0, sa[15-k], sb[15-k], 1'b1, lb, lb, 1'b1});
         if (k >= bp_from) begin
            up_valid = 1'b1;
            up_a     = 16'hA000 | 16'(k);
            up_b     = 16'h5A5A;
         end
      end
   endtask

   initial begin
      vecs[0] = '{16'h4126, 16'h4646, 16'h6482, 16'h6262, 16'h4126, 16'h4646};
      vecs[1] = '{16'hBEEF, 16'h1234, 16'hF77D, 16'h2C48, 16'hBEEF, 16'h1234};
      vecs[2] = '{16'h8001, 16'h7FFE, 16'h8001, 16'h7FFE, 16'h8001, 16'h7FFE};
      vecs[3] = '{16'hA5C3, 16'h0F0F, 16'hC3A5, 16'hF0F0, 16'hA5C3, 16'h0F0F};

      rst = 1'b1; up_valid = 1'b0; up_a = '0; up_b = '0;
      s_valid = 1'b0; s_a = '0; s_b = '0;
      #2;
      check("reset outputs", st1(), 7'b0000000);
      check("reset outputs w2", st2(), 7'b0000000);
      @(negedge clk);
      check("reset held", st1(), 7'b0000000);
      @(negedge clk);
      rst = 1'b0;
      #1 check("post-reset idle", st1(), 7'b0000010);

      // First transfer lands on the first rising edge after reset release.
      for (int v = 0; v < 4; v++) begin
         start_xfer(vecs[v].pa, vecs[v].pb);
         check_frame($sformatf("vec%0d", v), sel(vecs[v].la, vecs[v].ma), sel(vecs[v].lb, vecs[v].mb), 99, 16);
         @(negedge clk);
         check($sformatf("vec%0d idle", v), st1(), 7'b0000010);
      end

      // Back-to-back frames with up_valid held high.
      up_valid = 1'b1; up_a = 16'hFFFF; up_b = 16'h0000;
      @(posedge clk);
      #1 up_a = 16'h0001; up_b = 16'h0001;
      check_frame("b2b0", 16'hFFFF, 16'h0000, 99, 16);
      @(posedge clk);
      #1 up_valid = 1'b0;
      check_frame("b2b1", sel(16'h8000, 16'h0001), sel(16'h8000, 16'h0001), 99, 16);
      check_int("b2b clear spacing", clear_cyc - clear_cyc_prev, 17);
      @(negedge clk);
      check("b2b idle", st1(), 7'b0000010);

      // Backpressure: changing offer from bit 5 is only taken in the last cycle.
      start_xfer(16'h4126, 16'h4646);
      check_frame("bp0", sel(16'h6482, 16'h4126), sel(16'h6262, 16'h4646), 5, 16);
      @(posedge clk);
      #1 up_valid = 1'b0;
      check_frame("bp1", sel(16'hF005, 16'hA00F), 16'h5A5A, 99, 16);
      @(negedge clk);
      check("bp idle", st1(), 7'b0000010);

      // Reset asserted at bit 7 aborts the frame.
      start_xfer(16'h4126, 16'h4646);
      check_frame("rst0", sel(16'h6482, 16'h4126), sel(16'h6262, 16'h4646), 99, 7);
      @(posedge clk);
      #1 rst = 1'b1;
      #1 check("mid-frame reset", st1(), 7'b0000000);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check($sformatf("reset hold %0d", i), st1(), 7'b0000000);
      end
      rst = 1'b0;
      #1 check("reset release ready", st1(), 7'b0000010);
      for (int i = 0; i < 17; i++) begin
         @(negedge clk);
         check($sformatf("no residual bits %0d", i), st1(), 7'b0000010);
      end
      start_xfer(16'hBEEF, 16'h1234);
      check_frame("rst1", sel(16'hF77D, 16'hBEEF), sel(16'h2C48, 16'h1234), 99, 16);
      @(negedge clk);
      check("rst1 idle", st1(), 7'b0000010);

      // WIDTH=2 corner: clear, then two bits with last on the second.
      check("w2 idle", st2(), 7'b0000010);
      s_valid = 1'b1; s_a = 2'b10; s_b = 2'b01;
      @(posedge clk);
      #1 s_valid = 1'b0;
      @(negedge clk);
      check("w2 clear", st2(), 7'b1000001);
      @(negedge clk);
      check("w2 bit0", st2(), {1'b0, sel(16'h0001, 16'h0002) == 16'h0002, sel(16'h0001, 16'h0002) == 16'h0001, 4'b1001});
      @(negedge clk);
      check("w2 bit1", st2(), {1'b0, sel(16'h0001, 16'h0002) == 16'h0001, sel(16'h0001, 16'h0002) == 16'h0002, 4'b1111});
      @(negedge clk);
      check("w2 idle after", st2(), 7'b0000010);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
